instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Datapath-side responder to the control-unit FSM. It acts on the control strobes pc_load, ins_load and pc_inc.
- Owns the program counter and drives the synchronous instruction ROM address.
- Holds the instruction register and splits each instruction into opcode and operand-address fields.
- Captures the second word of two-word instructions (MVI, LDA) and feeds the opcode back to the control unit.

Parameters:
- ADDR_W, 8, program-counter and ROM address width.
- DATA_W, 16, instruction word width; must be 16.
- RST_PC, 0, program-counter value after reset.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  block enable; when 0, all strobes are ignored and state holds.
- pc_load  in  1  capture the current PC into pc_hold (control-unit load/byte2load states).
- ins_load  in  1  latch rom_data into IR, or into IMM when a second word is expected.
- pc_inc  in  1  advance the PC by 1.
- rom_addr  out  ADDR_W  ROM read address; combinational next-PC value.
- rom_data  in  DATA_W  ROM read data, 1-cycle registered read.
- opcode  out  4  IR[15:12], to the control unit.
- op1_addr  out  4  IR[11:8], destination/operand-1 register address.
- op2_addr  out  4  IR[7:4], operand-2 register address.
- imm  out  DATA_W  second instruction word (MVI data / LDA address).
- ir_valid  out  1  IR holds a latched instruction.
- imm_pending  out  1  IR holds a two-word opcode whose second word is not yet latched.
- pc  out  ADDR_W  current program counter.
- pc_hold  out  ADDR_W  PC value captured by the last pc_load.

Behaviour:
- Reset (rst=1 at an edge), regardless of en or strobes:
  - pc=RST_PC; pc_hold=0; IR=0 (so opcode/op1_addr/op2_addr = 0); imm=0; ir_valid=0; imm_pending=0.
- en=0 with rst=0: every register holds. rom_addr still equals pc.
- Next-PC:
  - pc_nxt = pc+1 (mod 2^ADDR_W) when en & pc_inc, else pc.
  - rom_addr = pc_nxt. Because of this look-ahead, rom_data in any cycle equals ROM[pc] of that cycle, with zero stall even right after an increment.
  - Wrap: pc = 2^ADDR_W-1 with pc_inc gives pc = 0. No flag is raised.
- pc_load (en=1): pc_hold <= pc, the pre-increment value if pc_inc is also asserted.
- ins_load (en=1) when imm_pending=0:
  - IR <= rom_data; ir_valid <= 1.
  - imm_pending <= 1 if rom_data[15:12] is MVI (4'b1100) or LDA (4'b1101); else 0.
- ins_load (en=1) when imm_pending=1:
  - imm <= rom_data; imm_pending <= 0. IR is unchanged, so opcode stays stable for the control unit's byte2 states.
- Simultaneous ins_load and pc_inc: the latch uses the pre-increment word (current rom_data); pc advances on the same edge.
- Control-unit cycle contract:
  - One-word instruction: load (pc_load+ins_load) -> execute (pc_inc). Opcode is valid in execute, one cycle after load.
  - Two-word instruction: load -> execute (pc_inc) -> byte2load (pc_load+ins_load, IMM latched) -> byte2execute (pc_inc).
  - Total pc advance per two-word instruction: 2.
- Outputs opcode, op1_addr, op2_addr and imm are pure register slices; no combinational path from rom_data.
- A default/illegal opcode is latched like any one-word instruction; no error is generated.
- Reset mid-instruction (e.g. between execute and byte2load): imm_pending is cleared, and the next ins_load treats its word as a new instruction.
- Synthesisable; no latches; no X or Z driven on any output.

Decomposition:
- Shared package cpu_isa_pkg:
  - Opcode constants: ADD 0000, MUL 0001, SUB 0010, DIV 0011, AND 0100, OR 0101, NOR 0110, INVA 0111, INVB 1000, XOR 1001, XNOR 1010, MOV 1011, MVI 1100, LDA 1101.
  - Instruction field positions: OPC 15:12, R1 11:8, R2 7:4.
  - ALU-mode encodings 00/01/10.
  - Function is_two_word(opcode).
- One sub-module: prog_counter. It holds the pc register, computes pc_nxt with wrap, and holds pc_hold. Instantiated once inside instr_fetch_unit.

Test Plan:
- Reset: rst=1 for 2 cycles with en=1 and strobes high -> pc=0, rom_addr=0, ir_valid=0, imm_pending=0, opcode=0. Releasing rst with no strobes -> all hold.
- One-word ADD:
  - Stimulus: ROM[0]=16'h0120; load cycle (pc_load, ins_load), then execute cycle (pc_inc).
  - Response after load: opcode=0000, op1_addr=1, op2_addr=2, pc_hold=0, imm_pending=0.
  - Response after execute: pc=1, rom_addr showed 1 during execute.
- Two-word MVI:
  - Stimulus: ROM[1]=16'hC300, ROM[2]=16'h00AB; run the full load/execute/byte2load/byte2execute sequence from pc=1.
  - Response: opcode=1100 throughout; imm_pending=1 after load, 0 after byte2load; imm=16'h00AB; pc_hold=2; final pc=3.
- Wrap: pc=255 (ADDR_W=8) with pc_inc -> pc=0, rom_addr=0 in the increment cycle; ROM[0] content appears on rom_data the next cycle.
- en=0 gating: en=0 with pc_inc, ins_load and pc_load all high for 3 cycles -> pc, IR, imm and pc_hold unchanged.
- Reset mid two-word instruction:
  - Stimulus: LDA (16'hD000) latched, then rst pulse; then ins_load with ROM[0]=16'h4560.
  - Response: imm_pending=0 after rst; IR=16'h4560 with opcode AND; imm unchanged at 0.

Source files
------------

// File: rtl/cpu_isa_pkg.sv
// ISA definitions shared by the datapath and control unit: opcodes, instruction
// field positions, ALU modes and the two-word opcode test.
package cpu_isa_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_MUL  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_NOR  = 4'b0110;
    localparam logic [3:0] OP_INVA = 4'b0111;
    localparam logic [3:0] OP_INVB = 4'b1000;
    localparam logic [3:0] OP_XOR  = 4'b1001;
    localparam logic [3:0] OP_XNOR = 4'b1010;
    localparam logic [3:0] OP_MOV  = 4'b1011;
    localparam logic [3:0] OP_MVI  = 4'b1100;
    localparam logic [3:0] OP_LDA  = 4'b1101;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int R1_HI  = 11;
    localparam int R1_LO  = 8;
    localparam int R2_HI  = 7;
    localparam int R2_LO  = 4;

    typedef enum logic [1:0] {
        ALU_ARITH = 2'b00,
        ALU_LOGIC = 2'b01,
        ALU_MOVE  = 2'b10
    } alu_mode_e;

    typedef struct packed {
        logic [3:0] opc;
        logic [3:0] r1;
        logic [3:0] r2;
        logic [3:0] rsvd;
    } instr_t;

    function automatic logic is_two_word(input logic [3:0] opc);
        return (opc == OP_MVI) || (opc == OP_LDA);
    endfunction

endpackage

// File: rtl/prog_counter.sv
// Program counter with wrap-around look-ahead next value and a pc_hold capture
// register; the look-ahead drives the synchronous ROM address.
module prog_counter
    import cpu_isa_pkg::*;
#(
    parameter int                ADDR_W = 8,
    parameter logic [ADDR_W-1:0] RST_PC = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_pc_inc,
    input  logic              i_pc_load,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_pc_nxt,
    output logic [ADDR_W-1:0] o_pc_hold
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_pc_hold;
    logic [ADDR_W-1:0] w_pc_nxt;

    // Reset steers the look-ahead too, so the first word after reset is ROM[RST_PC].
    always_comb begin
        w_pc_nxt = r_pc;
        if (i_rst)
            w_pc_nxt = RST_PC;
        else if (i_en && i_pc_inc)
            w_pc_nxt = r_pc + ADDR_W'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc      <= RST_PC;
            r_pc_hold <= '0;
        end else if (i_en) begin
            r_pc <= w_pc_nxt;
            if (i_pc_load)
                r_pc_hold <= r_pc;
        end
    end

    assign o_pc      = r_pc;
    assign o_pc_nxt  = w_pc_nxt;
    assign o_pc_hold = r_pc_hold;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch datapath: owns the PC, latches the instruction register and
// the second word of MVI/LDA, and exposes the decoded fields to the control unit.
module instr_fetch_unit
    import cpu_isa_pkg::*;
#(
    parameter int                ADDR_W = 8,
    parameter int                DATA_W = 16,
    parameter logic [ADDR_W-1:0] RST_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              pc_load,
    input  logic              ins_load,
    input  logic              pc_inc,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [3:0]        opcode,
    output logic [3:0]        op1_addr,
    output logic [3:0]        op2_addr,
    output logic [DATA_W-1:0] imm,
    output logic              ir_valid,
    output logic              imm_pending,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_hold
);

    instr_t            r_ir;
    logic [DATA_W-1:0] r_imm;
    logic              r_ir_valid;
    logic              r_imm_pending;
    logic [ADDR_W-1:0] w_pc_nxt;

    prog_counter #(
        .ADDR_W (ADDR_W),
        .RST_PC (RST_PC)
    ) u_pc (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_en      (en),
        .i_pc_inc  (pc_inc),
        .i_pc_load (pc_load),
        .o_pc      (pc),
        .o_pc_nxt  (w_pc_nxt),
        .o_pc_hold (pc_hold)
    );

    // While a second word is owed, ins_load fills IMM and IR stays put for the byte2 states.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ir          <= '0;
            r_imm         <= '0;
            r_ir_valid    <= 1'b0;
            r_imm_pending <= 1'b0;
        end else if (en && ins_load) begin
            if (r_imm_pending) begin
                r_imm         <= rom_data;
                r_imm_pending <= 1'b0;
            end else begin
                r_ir          <= instr_t'(rom_data);
                r_ir_valid    <= 1'b1;
                r_imm_pending <= is_two_word(rom_data[OPC_HI:OPC_LO]);
            end
        end
    end

    logic w_unused_ir;
    assign w_unused_ir = &{1'b0, r_ir.rsvd};

    assign rom_addr    = w_pc_nxt;
    assign opcode      = r_ir.opc;
    assign op1_addr    = r_ir.r1;
    assign op2_addr    = r_ir.r2;
    assign imm         = r_imm;
    assign ir_valid    = r_ir_valid;
    assign imm_pending = r_imm_pending;

endmodule
